axis_stim_source: RTL

AXI4-Stream master that generates programmable test stimulus for the FIR filter's `s_axis_data` input port, so the filter can be exercised on hardware without an external sample source. It produces bursts of impulse, step, ramp or pseudo-random samples at a programmable sample period. It honours `tready` backpressure fully. It reports completion to the control logic.

---
 rtl/stim_pkg.sv | 29 ++
 rtl/stim_lfsr16.sv | 37 +++
 rtl/axis_stim_source.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared types and constants for the AXI4-Stream stimulus source.
package stim_pkg;

  // Sample-generation modes, encoded as seen on the mode input.
  typedef enum logic [1:0] {
    ModeImpulse = 2'd0,
    ModeStep    = 2'd1,
    ModeRamp    = 2'd2,
    ModeLfsr    = 2'd3
  } mode_e;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
  // Fibonacci x^16+x^14+x^13+x^11+1 seen from the shift-right side: bits 0, 2, 3, 5.
  localparam logic [15:0] LfsrTaps = 16'h002D;

  // One LFSR step: feedback enters at the MSB, register shifts right.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {^(s & LfsrTaps), s[15:1]};
  endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload and advance enables.
module stim_lfsr16
  import stim_pkg::*;
#(
  parameter logic [15:0] Seed = LfsrSeedDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] next_o
);

  logic [15:0] state_q, state_d;

  assign next_o = lfsr16_next(state_q);

  // Reload wins over advance so a new burst always starts from the seed.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = Seed;
    end else if (adv_i) begin
      state_d = next_o;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/axis_stim_source.sv
// AXI4-Stream stimulus master: impulse/step/ramp/LFSR bursts at a programmable
// sample period, with full tready backpressure and a done pulse at the end.
module axis_stim_source
  import stim_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PERIOD_W  = 16,
  parameter int unsigned COUNT_W   = 16,
  parameter logic [15:0] LFSR_SEED = LfsrSeedDefault
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  num_samples,
  input  logic [DATA_W-1:0]   amplitude,
  output logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tready,
  output logic [DATA_W-1:0]   m_axis_data_tdata,
  output logic                m_axis_data_tlast,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  sent_count
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;  // effective period, never zero
  logic [PERIOD_W-1:0] gap_q, gap_d;
  logic [COUNT_W-1:0]  num_q, num_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic [COUNT_W-1:0]  sent_q, sent_d;      // doubles as index of the pending sample
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tlast_q, tlast_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                lfsr_load, lfsr_adv;
  logic [15:0]         lfsr_next;
  logic                hs;
  logic [COUNT_W-1:0]  k_next;
  logic [DATA_W-1:0]   first_sample, next_sample;

  stim_lfsr16 #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (aclk),
    .rst_i  (areset),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .next_o (lfsr_next)
  );

  assign hs     = tvalid_q & m_axis_data_tready;
  assign k_next = sent_q + COUNT_W'(1);

  // Sample values: k=0 from the start inputs, k+1 from latched config after a handshake.
  always_comb begin
    first_sample = '0;
    next_sample  = '0;
    unique case (mode_e'(mode))
      ModeImpulse: first_sample = amplitude;
      ModeStep:    first_sample = amplitude;
      ModeRamp:    first_sample = '0;
      ModeLfsr:    first_sample = DATA_W'(LFSR_SEED);
    endcase
    unique case (mode_q)
      ModeImpulse: next_sample = '0;
      ModeStep:    next_sample = amp_q;
      ModeRamp:    next_sample = DATA_W'(k_next);
      ModeLfsr:    next_sample = DATA_W'(lfsr_next);
    endcase
  end

  // Next-state and registered-output logic; outputs only move on handshakes or transitions.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    gap_d     = gap_q;
    num_d     = num_q;
    amp_d     = amp_q;
    sent_d    = sent_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode_e'(mode);
          period_d  = (period == '0) ? PERIOD_W'(1) : period;
          num_d     = num_samples;
          amp_d     = amplitude;
          sent_d    = '0;
          lfsr_load = 1'b1;
          if (num_samples == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d  = StSend;
            tvalid_d = 1'b1;
            busy_d   = 1'b1;
            tdata_d  = first_sample;
            tlast_d  = (num_samples == COUNT_W'(1));
          end
        end
      end
      StSend: begin
        if (hs) begin
          sent_d   = k_next;
          lfsr_adv = 1'b1;
          if (tlast_q) begin
            state_d  = StDone;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            tdata_d = next_sample;
            tlast_d = (k_next == num_q - COUNT_W'(1));
            if (period_q == PERIOD_W'(1)) begin
              tvalid_d = 1'b1;
            end else begin
              // Gap of P-1 low cycles: this count plus the final GAP->SEND cycle.
              state_d  = StGap;
              tvalid_d = 1'b0;
              gap_d    = period_q - PERIOD_W'(2);
            end
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d  = StSend;
          tvalid_d = 1'b1;
        end else begin
          gap_d = gap_q - PERIOD_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= StIdle;
      mode_q   <= ModeImpulse;
      period_q <= PERIOD_W'(1);
      gap_q    <= '0;
      num_q    <= '0;
      amp_q    <= '0;
      sent_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      gap_q    <= gap_d;
      num_q    <= num_d;
      amp_q    <= amp_d;
      sent_q   <= sent_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_data_tvalid = tvalid_q;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tlast  = tlast_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign sent_count         = sent_q;

endmodule
